// File: rtl/freqdiv_ctrl.sv
// freqdiv_ctrl: run/stop controller and programmable half-period divider.
// Produces a square wave clk_out and a one-cycle tick on every clk_out toggle.
// A new divisor is accepted over a valid/ready port. While stopped it takes
// effect on the next cycle. While running it is held as pending and applied
// on the next counter wrap, so a half-period in progress always completes
// with the old divisor.
// Optional feature macro: FREQDIV_CTRL_ONESHOT_EN. When defined, it adds the
// oneshot/done ports and a single-period mode.
module freqdiv_ctrl #(
    parameter int CNT_W       = 26,
    parameter int DIV_DEFAULT = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic [CNT_W-1:0] div_active
`ifdef FREQDIV_CTRL_ONESHOT_EN
    ,
    input  logic             oneshot,
    output logic             done
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);

    state_t           state_r, state_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic             clk_out_r, clk_out_s;
    logic             tick_r, tick_s;
    logic             running_r, running_s;
    logic             cfg_ready_r, cfg_ready_s;
    logic [CNT_W-1:0] div_r, div_s;
    logic             pend_r, pend_s;
    logic [CNT_W-1:0] pend_div_r, pend_div_s;
`ifdef FREQDIV_CTRL_ONESHOT_EN
    logic             os_r, os_s;
    logic             tog_r, tog_s;
    logic             done_r, done_s;
`endif

    logic             xfer_s;
    logic             wrap_s;
    logic [CNT_W-1:0] cfg_clamped_s;

    // A divisor of zero is stored as one. The wrap compare uses >= so that the
    // counter can never run past the current divisor.
    always_comb begin
        xfer_s        = cfg_valid & cfg_ready_r;
        cfg_clamped_s = (cfg_div == ZERO) ? ONE : cfg_div;
        wrap_s        = (count_r >= (div_r - ONE));
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_s     = state_r;
        count_s     = count_r;
        clk_out_s   = clk_out_r;
        tick_s      = 1'b0;
        running_s   = running_r;
        cfg_ready_s = cfg_ready_r;
        div_s       = div_r;
        pend_s      = pend_r;
        pend_div_s  = pend_div_r;
`ifdef FREQDIV_CTRL_ONESHOT_EN
        os_s        = os_r;
        tog_s       = tog_r;
        done_s      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                count_s     = ZERO;
                clk_out_s   = 1'b1;
                running_s   = 1'b0;
                cfg_ready_s = 1'b1;
                if (xfer_s) begin
                    div_s = cfg_clamped_s;
                end else begin
                    div_s = div_r;
                end
                if (start && !stop) begin
                    state_s   = RUN;
                    running_s = 1'b1;
`ifdef FREQDIV_CTRL_ONESHOT_EN
                    os_s      = oneshot;
                    tog_s     = 1'b0;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s     = IDLE;
                    count_s     = ZERO;
                    clk_out_s   = 1'b1;
                    running_s   = 1'b0;
                    cfg_ready_s = 1'b1;
                    pend_s      = 1'b0;
`ifdef FREQDIV_CTRL_ONESHOT_EN
                    os_s        = 1'b0;
`endif
                    if (pend_r) begin
                        div_s = pend_div_r;
                    end else if (xfer_s) begin
                        div_s = cfg_clamped_s;
                    end else begin
                        div_s = div_r;
                    end
                end else begin
                    if (xfer_s) begin
                        pend_s      = 1'b1;
                        pend_div_s  = cfg_clamped_s;
                        cfg_ready_s = 1'b0;
                    end else begin
                        pend_s = pend_r;
                    end
                    if (wrap_s) begin
                        count_s   = ZERO;
                        clk_out_s = ~clk_out_r;
                        tick_s    = 1'b1;
                        if (pend_r) begin
                            div_s       = pend_div_r;
                            pend_s      = 1'b0;
                            cfg_ready_s = 1'b1;
                        end else begin
                            div_s = div_r;
                        end
`ifdef FREQDIV_CTRL_ONESHOT_EN
                        if (os_r) begin
                            if (tog_r) begin
                                state_s   = IDLE;
                                running_s = 1'b0;
                                done_s    = 1'b1;
                                os_s      = 1'b0;
                                tog_s     = 1'b0;
                            end else begin
                                tog_s = 1'b1;
                            end
                        end else begin
                            tog_s = tog_r;
                        end
`endif
                    end else begin
                        count_s = count_r + ONE;
                    end
                end
            end
            default: begin
                state_s     = IDLE;
                count_s     = ZERO;
                clk_out_s   = 1'b1;
                running_s   = 1'b0;
                cfg_ready_s = 1'b1;
                pend_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any pending divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= ZERO;
            clk_out_r   <= 1'b1;
            tick_r      <= 1'b0;
            running_r   <= 1'b0;
            cfg_ready_r <= 1'b1;
            div_r       <= DIV_INIT;
            pend_r      <= 1'b0;
            pend_div_r  <= ZERO;
`ifdef FREQDIV_CTRL_ONESHOT_EN
            os_r        <= 1'b0;
            tog_r       <= 1'b0;
            done_r      <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            count_r     <= count_s;
            clk_out_r   <= clk_out_s;
            tick_r      <= tick_s;
            running_r   <= running_s;
            cfg_ready_r <= cfg_ready_s;
            div_r       <= div_s;
            pend_r      <= pend_s;
            pend_div_r  <= pend_div_s;
`ifdef FREQDIV_CTRL_ONESHOT_EN
            os_r        <= os_s;
            tog_r       <= tog_s;
            done_r      <= done_s;
`endif
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign clk_out    = clk_out_r;
    assign tick       = tick_r;
    assign running    = running_r;
    assign div_active = div_r;
`ifdef FREQDIV_CTRL_ONESHOT_EN
    assign done       = done_r;
`endif

endmodule

// File: tb/tb_freqdiv_ctrl.sv
// Testbench for freqdiv_ctrl (DIV_DEFAULT overridden to 4).
// Expected tick cycles are pushed to a queue when a run is started or a
// divisor change is scheduled. A negedge monitor pops one entry per observed
// tick and compares cycle numbers. Direct checks cover static outputs.
// The oneshot scenario is compiled only with FREQDIV_CTRL_ONESHOT_EN.
module tb_freqdiv_ctrl;

    localparam int CNT_W = 26;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_div = '0;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic [CNT_W-1:0] div_active;
`ifdef FREQDIV_CTRL_ONESHOT_EN
    logic             oneshot = 1'b0;
    logic             done;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_ticks[$];

    freqdiv_ctrl #(.CNT_W(CNT_W), .DIV_DEFAULT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .div_active (div_active)
`ifdef FREQDIV_CTRL_ONESHOT_EN
        ,
        .oneshot    (oneshot),
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    // Cycle counter: value k holds from posedge k until posedge k+1.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Tick scoreboard: every observed tick must match the next expected cycle.
    always @(negedge clk) begin
        if (!rst && tick) begin
            if (exp_ticks.size() == 0) begin
                check_val("tick_unexpected", 32'(tick), 32'd0);
            end else begin
                check_val("tick_cycle", 32'(cyc), 32'(exp_ticks.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_cfg(input logic [CNT_W-1:0] v);
        cfg_valid = 1'b1;
        cfg_div   = v;
        step(1);
        cfg_valid = 1'b0;
    endtask

    // Pulses start; r is the first cycle in which running is high.
    task automatic start_run(output int r);
        start = 1'b1;
        r     = cyc + 1;
        step(1);
        start = 1'b0;
        check_val("running_rise", 32'(running), 32'd1);
    endtask

    task automatic push_ticks(input int r, input int div, input int n);
        for (int k = 1; k <= n; k++) exp_ticks.push_back(r + div * k);
    endtask

    task automatic stop_run();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check_val("stop_running", 32'(running), 32'd0);
        check_val("stop_clk_out", 32'(clk_out), 32'd1);
        check_val("stop_tick", 32'(tick), 32'd0);
    endtask

    task automatic drain_check(input string tag);
        step(2);
        check_val(tag, 32'(exp_ticks.size()), 32'd0);
        exp_ticks.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        step(3);
        rst = 1'b0;
        step(1);

        // 1: reset values, default divisor 4
        check_val("rst_clk_out", 32'(clk_out), 32'd1);
        check_val("rst_div", 32'(div_active), 32'd4);
        check_val("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check_val("rst_running", 32'(running), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        start_run(r);
        push_ticks(r, 4, 3);
        wait_cyc(r + 4);
        check_val("t1_clk_out_lo", 32'(clk_out), 32'd0);
        wait_cyc(r + 13);
        stop_run();
        drain_check("t1_ticks_left");

        // 2: divisor 3 loaded while idle
        load_cfg(26'd3);
        check_val("t2_div", 32'(div_active), 32'd3);
        check_val("t2_cfg_ready", 32'(cfg_ready), 32'd1);
        start_run(r);
        push_ticks(r, 3, 3);
        wait_cyc(r + 3);
        check_val("t2_clk_out_lo", 32'(clk_out), 32'd0);
        wait_cyc(r + 6);
        check_val("t2_clk_out_hi", 32'(clk_out), 32'd1);
        wait_cyc(r + 10);
        stop_run();
        drain_check("t2_ticks_left");

        // 3: divisor 5 running, load 2 at count 1
        load_cfg(26'd5);
        start_run(r);
        wait_cyc(r + 1);
        load_cfg(26'd2);
        check_val("t3_ready_low", 32'(cfg_ready), 32'd0);
        check_val("t3_div_old", 32'(div_active), 32'd5);
        exp_ticks.push_back(r + 5);
        push_ticks(r + 5, 2, 3);
        wait_cyc(r + 4);
        check_val("t3_ready_still_low", 32'(cfg_ready), 32'd0);
        wait_cyc(r + 5);
        check_val("t3_ready_high", 32'(cfg_ready), 32'd1);
        check_val("t3_div_new", 32'(div_active), 32'd2);
        wait_cyc(r + 12);
        stop_run();
        drain_check("t3_ticks_left");

        // 4: start+stop together in idle, then stop at count 2
        load_cfg(26'd5);
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        check_val("t4_stay_idle", 32'(running), 32'd0);
        start_run(r);
        wait_cyc(r + 2);
        stop_run();
        step(6);
        drain_check("t4_ticks_left");

        // 5: divisor 0 clamps to 1
        load_cfg(26'd0);
        check_val("t5_div_clamp", 32'(div_active), 32'd1);
        start_run(r);
        push_ticks(r, 1, 8);
        wait_cyc(r + 1);
        check_val("t5_clk_out_lo", 32'(clk_out), 32'd0);
        wait_cyc(r + 2);
        check_val("t5_clk_out_hi", 32'(clk_out), 32'd1);
        check_val("t5_tick_high", 32'(tick), 32'd1);
        wait_cyc(r + 8);
        stop_run();
        drain_check("t5_ticks_left");

        // stop while a divisor is pending applies it on entry to idle
        load_cfg(26'd4);
        start_run(r);
        load_cfg(26'd3);
        check_val("pend_ready_low", 32'(cfg_ready), 32'd0);
        stop_run();
        check_val("pend_div_applied", 32'(div_active), 32'd3);
        check_val("pend_ready_high", 32'(cfg_ready), 32'd1);
        drain_check("pend_ticks_left");

        // async reset mid-run discards the pending divisor
        start_run(r);
        load_cfg(26'd6);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_running", 32'(running), 32'd0);
        check_val("arst_clk_out", 32'(clk_out), 32'd1);
        check_val("arst_div", 32'(div_active), 32'd4);
        check_val("arst_ready", 32'(cfg_ready), 32'd1);
        check_val("arst_tick", 32'(tick), 32'd0);
        exp_ticks.delete();
        step(1);
        rst = 1'b0;
        step(1);
        start_run(r);
        push_ticks(r, 4, 2);
        wait_cyc(r + 8);
        check_val("arst_pend_dropped", 32'(div_active), 32'd4);
        wait_cyc(r + 9);
        stop_run();
        drain_check("arst_ticks_left");

`ifdef FREQDIV_CTRL_ONESHOT_EN
        // 6: oneshot with divisor 3
        load_cfg(26'd3);
        oneshot = 1'b1;
        start_run(r);
        oneshot = 1'b0;
        push_ticks(r, 3, 2);
        wait_cyc(r + 3);
        check_val("os_clk_out_lo", 32'(clk_out), 32'd0);
        check_val("os_done_early", 32'(done), 32'd0);
        wait_cyc(r + 6);
        check_val("os_clk_out_hi", 32'(clk_out), 32'd1);
        check_val("os_done_pulse", 32'(done), 32'd1);
        check_val("os_running_low", 32'(running), 32'd0);
        wait_cyc(r + 7);
        check_val("os_done_clear", 32'(done), 32'd0);
        step(6);
        drain_check("os_ticks_left");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
